// File: rtl/ssd_pkg.sv
// Shared glyph codes and seven-segment patterns for the scan driver and
// any other display consumer (e.g. a future VGA HUD).
package ssd_pkg;

    localparam logic [4:0] GLY_BLANK = 5'h10;
    localparam logic [4:0] GLY_E     = 5'h11;
    localparam logic [4:0] GLY_L     = 5'h12;
    localparam logic [4:0] GLY_R     = 5'h13;
    localparam logic [4:0] GLY_DASH  = 5'h14;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        CM_IDLE,
        CM_PENDING
    } commit_state_e;

    // Active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg}; unused codes show blank.
    function automatic logic [6:0] seg7_of(input logic [4:0] glyph);
        logic [6:0] p;
        case (glyph)
            5'h00:     p = 7'b0000001;
            5'h01:     p = 7'b1001111;
            5'h02:     p = 7'b0010010;
            5'h03:     p = 7'b0000110;
            5'h04:     p = 7'b1001100;
            5'h05:     p = 7'b0100100;
            5'h06:     p = 7'b0100000;
            5'h07:     p = 7'b0001111;
            5'h08:     p = 7'b0000000;
            5'h09:     p = 7'b0000100;
            5'h0A:     p = 7'b0001000;
            5'h0B:     p = 7'b1100000;
            5'h0C:     p = 7'b0110001;
            5'h0D:     p = 7'b1000010;
            5'h0E:     p = 7'b0110000;
            5'h0F:     p = 7'b0111000;
            GLY_BLANK: p = 7'b1111111;
            GLY_E:     p = 7'b0110000;
            GLY_L:     p = 7'b1110001;
            GLY_R:     p = 7'b1111010;
            GLY_DASH:  p = 7'b1111110;
            default:   p = 7'b1111111;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Glyph write / commit port of the scan driver. The game controller is the
// master; the driver answers with a commit_done pulse.
interface ssd_scan_driver_if #(
    parameter int AW = 3
) ();
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [4:0]    wr_glyph;
    logic          wr_dp;
    logic          commit;
    logic          commit_done;

    modport master (
        output wr_en, wr_addr, wr_glyph, wr_dp, commit,
        input  commit_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_glyph, wr_dp, commit,
        output commit_done
    );
endinterface

// File: rtl/ssd_glyph_decode.sv
// Combinational glyph + decimal point to active-low segment byte.
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [4:0] glyph,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = {seg7_of(glyph), ~dp};
endmodule

// File: rtl/ssd_scan_driver.sv
// Seven-segment scan driver: double-buffered glyphs, blanking, blink and a
// commit that copies shadow to active only on a frame boundary.
//   state      | meaning
//   CM_IDLE    | no commit requested
//   CM_PENDING | commit requested, copy on next frame wrap
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter  int NUM_DIGITS   = 8,
    parameter  int SCAN_DIV     = 262144,
    parameter  int BLANK_CYCLES = 64,
    parameter  int BLINK_FRAMES = 64,
    localparam int AW           = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ssd_scan_driver_if.slave      bus,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg,
    output logic [AW-1:0]         scan_idx,
    output logic                  frame_tick
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0]         presc;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_phase;
    logic                  slot_tick;
    logic                  frame_wrap;
    logic [4:0]            shadow_glyph [NUM_DIGITS];
    logic [4:0]            active_glyph [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] active_dp;
    commit_state_e         state;
    commit_state_e         state_nxt;
    logic                  do_copy;
    logic [NUM_DIGITS-1:0] lit_mask;
    logic [4:0]            cur_glyph;
    logic                  cur_dp;
    logic [7:0]            dec_seg;

    assign slot_tick  = (presc == PW'(SCAN_DIV - 1));
    assign frame_wrap = slot_tick && (scan_idx == AW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            scan_idx    <= '0;
            frame_tick  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            presc      <= slot_tick ? '0 : presc + 1'b1;
            frame_tick <= frame_wrap;
            if (slot_tick)
                scan_idx <= frame_wrap ? '0 : scan_idx + 1'b1;
            if (frame_wrap) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= CM_IDLE;
        else
            state <= state_nxt;
    end

    // A commit arriving on the copy edge re-arms, so it is never lost.
    always_comb begin
        state_nxt = state;
        do_copy   = 1'b0;
        case (state)
            CM_IDLE: if (bus.commit) state_nxt = CM_PENDING;
            CM_PENDING: begin
                if (frame_wrap) begin
                    do_copy = 1'b1;
                    if (!bus.commit) state_nxt = CM_IDLE;
                end
            end
            default: state_nxt = CM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_glyph[i] <= GLY_BLANK;
                active_glyph[i] <= GLY_BLANK;
            end
            shadow_dp       <= '0;
            active_dp       <= '0;
            bus.commit_done <= 1'b0;
        end else begin
            bus.commit_done <= do_copy;
            if (do_copy) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    active_glyph[i] <= shadow_glyph[i];
                active_dp <= shadow_dp;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus.wr_en && bus.wr_addr == AW'(i)) begin
                    shadow_glyph[i] <= bus.wr_glyph;
                    shadow_dp[i]    <= bus.wr_dp;
                end
            end
        end
    end

    always_comb begin
        lit_mask  = '0;
        cur_glyph = GLY_BLANK;
        cur_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == AW'(i)) begin
                cur_glyph   = active_glyph[i];
                cur_dp      = active_dp[i];
                lit_mask[i] = digit_en[i] && (!blink_mask[i] || blink_phase);
            end
        end
        if (presc < PW'(BLANK_CYCLES))
            lit_mask = '0;
    end

    ssd_glyph_decode u_decode (
        .glyph (cur_glyph),
        .dp    (cur_dp),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else begin
            an  <= ~lit_mask;
            seg <= (|lit_mask) ? dec_seg : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver with 4 digits, 8-cycle slots,
// 2 blanking cycles and 2-frame blink half-period.
module tb_ssd_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_en;
    logic [3:0] blink_mask;
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] scan_idx;
    logic       frame_tick;

    ssd_scan_driver_if #(.AW(2)) bus ();

    ssd_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Edge count since the last reset release; at the negedge after edge e it reads e.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    localparam logic [7:0] S_BLANK = 8'hFF;
    localparam logic [7:0] S_ZERO  = 8'b0000_0011;
    localparam logic [7:0] S_E_DP  = 8'b0110_0000;
    localparam logic [7:0] S_L     = 8'b1110_0011;
    localparam logic [7:0] S_THREE = 8'b0000_1101;

    // kind 0 = frame_tick, 1 = commit_done, 2 = display (an/seg not idle)
    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 1'b0;

    function automatic string kind_name(int k);
        if (k == 0) return "frame_tick";
        if (k == 1) return "commit_done";
        return "display";
    endfunction

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endfunction

    function automatic void sb_add(int c, int k, logic [3:0] a, logic [7:0] s);
        exp_t e;
        int   pos;
        e.cyc  = c;
        e.kind = k;
        e.an   = a;
        e.seg  = s;
        pos    = sb.size();
        while (pos > 0 && (sb[pos-1].cyc * 4 + sb[pos-1].kind) > (c * 4 + k))
            pos--;
        sb.insert(pos, e);
    endfunction

    function automatic logic [3:0] an_of(int d);
        logic [3:0] v;
        v = 4'b0001;
        return ~(v << d);
    endfunction

    // Digit d of frame f drives its anode on edges 32f+8d+3 .. 32f+8d+8.
    function automatic void push_slot(int f, int d, logic [7:0] s, int limit);
        for (int k = 0; k < 6; k++) begin
            if (32 * f + 8 * d + 3 + k <= limit)
                sb_add(32 * f + 8 * d + 3 + k, 2, an_of(d), s);
        end
    endfunction

    function automatic void push_frame(int f, logic [3:0] lit, logic [7:0] s0,
                                       logic [7:0] s1, logic [7:0] s2, logic [7:0] s3);
        if (lit[0]) push_slot(f, 0, s0, 1 << 30);
        if (lit[1]) push_slot(f, 1, s1, 1 << 30);
        if (lit[2]) push_slot(f, 2, s2, 1 << 30);
        if (lit[3]) push_slot(f, 3, s3, 1 << 30);
        sb_add(32 * (f + 1), 0, 4'hF, 8'hFF);
    endfunction

    function automatic void flush_before(int c);
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < c) begin
            e = sb.pop_front();
            n_checks++;
            $display("FAIL missed %s at cycle %0d: got nothing, expected an=%b seg=%b",
                     kind_name(e.kind), e.cyc, e.an, e.seg);
        end
    endfunction

    function automatic void observe(int k, logic [3:0] a, logic [7:0] s);
        exp_t e;
        flush_before(cyc);
        if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].kind == k) begin
            e = sb.pop_front();
            n_checks++;
            if (k == 2 && (a !== e.an || s !== e.seg))
                $display("FAIL display at cycle %0d: got an=%b seg=%b, expected an=%b seg=%b",
                         cyc, a, s, e.an, e.seg);
            else
                n_pass++;
        end else begin
            n_checks++;
            $display("FAIL unexpected %s at cycle %0d: got an=%b seg=%b, expected none",
                     kind_name(k), cyc, a, s);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && !done) begin
            if (frame_tick)      observe(0, an, seg);
            if (bus.commit_done) observe(1, an, seg);
            if (an !== 4'hF || seg !== 8'hFF) observe(2, an, seg);
            flush_before(cyc + 1);
        end
    end

    task automatic wait_edge(int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic write_at(int e, logic [1:0] a, logic [4:0] g, logic d);
        wait_edge(e - 1);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = a;
        bus.wr_glyph = g;
        bus.wr_dp    = d;
        wait_edge(e);
        bus.wr_en    = 1'b0;
    endtask

    task automatic commit_at(int e);
        wait_edge(e - 1);
        bus.commit = 1'b1;
        wait_edge(e);
        bus.commit = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_an"},          int'(an),              'hF);
        check({tag, "_seg"},         int'(seg),             'hFF);
        check({tag, "_frame_tick"},  int'(frame_tick),      0);
        check({tag, "_commit_done"}, int'(bus.commit_done), 0);
        check({tag, "_scan_idx"},    int'(scan_idx),        0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_addr  = 2'd0;
        bus.wr_glyph = 5'd0;
        bus.wr_dp    = 1'b0;
        bus.commit   = 1'b0;
        digit_en     = 4'hF;
        blink_mask   = 4'h0;

        #12;
        check_reset_outputs("reset");

        // Frames 0-1: blank glyphs on every enabled digit; commit lands at edge 64.
        push_frame(0, 4'hF, S_BLANK, S_BLANK, S_BLANK, S_BLANK);
        push_frame(1, 4'hF, S_BLANK, S_BLANK, S_BLANK, S_BLANK);
        sb_add(64, 1, 4'hF, 8'hFF);

        @(negedge clk);
        #2 rst_n = 1'b1;

        write_at(40, 2'd1, 5'h00, 1'b0);
        write_at(41, 2'd2, 5'h11, 1'b1);
        commit_at(45);
        check("scan_idx_mid_frame", int'(scan_idx), 1);
        commit_at(50);

        // Frames 2-3: only digits 1 and 2 enabled, new glyphs visible.
        wait_edge(64);
        digit_en = 4'b0110;
        push_frame(2, 4'b0110, S_BLANK, S_ZERO, S_E_DP, S_BLANK);
        push_frame(3, 4'b0110, S_BLANK, S_ZERO, S_E_DP, S_BLANK);

        // Frames 4-9: digit1 blinks; blink phase is visible in 4,5,8,9.
        wait_edge(128);
        blink_mask = 4'b0010;
        for (int f = 4; f < 10; f++) begin
            if (f == 6 || f == 7)
                push_frame(f, 4'b0100, S_BLANK, S_ZERO, S_E_DP, S_BLANK);
            else
                push_frame(f, 4'b0110, S_BLANK, S_ZERO, S_E_DP, S_BLANK);
        end

        // Frames 10-12: write on the copy edge waits for the following commit.
        wait_edge(320);
        digit_en   = 4'hF;
        blink_mask = 4'h0;
        push_frame(10, 4'hF, S_BLANK, S_ZERO, S_E_DP, S_BLANK);
        push_frame(11, 4'hF, S_BLANK, S_ZERO, S_E_DP, S_L);
        push_frame(12, 4'hF, S_THREE, S_ZERO, S_E_DP, S_L);
        sb_add(352, 1, 4'hF, 8'hFF);
        sb_add(384, 1, 4'hF, 8'hFF);
        write_at(330, 2'd3, 5'h12, 1'b0);
        commit_at(335);
        write_at(352, 2'd0, 5'h03, 1'b0);
        commit_at(360);

        // Frame 13: reset while digit1 is lit and a commit is pending.
        wait_edge(416);
        push_slot(13, 0, S_THREE, 429);
        push_slot(13, 1, S_ZERO, 429);
        write_at(418, 2'd0, 5'h14, 1'b0);
        commit_at(420);
        wait_edge(429);
        check("lit_before_reset", int'(an), 'hD);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("sb_empty_at_reset", sb.size(), 0);

        push_frame(0, 4'hF, S_BLANK, S_BLANK, S_BLANK, S_BLANK);
        push_slot(1, 0, S_BLANK, 40);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_edge(40);
        @(negedge clk);

        done = 1'b1;
        flush_before(1 << 30);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
